// File: rtl/gray_counter.sv
// Purpose: registered up/down counter held in Gray code with load, wrap/saturate and over/underflow pulses.
// Latency: every update (reset, load, step) is visible on gray one cycle after the sampling edge.
// Backpressure: none; the counter accepts an input on every cycle. Optional macro GRAY_COUNTER_BINARY_OUTPUT_EN adds a registered binary port.
module gray_counter #(
  parameter int          WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] gray,
`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
  output logic [WIDTH-1:0] binary,
`endif
  output logic             at_max,
  output logic             at_min,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  // Gray encoding of all-ones binary is a lone MSB.
  localparam logic [WIDTH-1:0] MAX_GRAY = {1'b1, {(WIDTH-1){1'b0}}};

  // Prefix-XOR from the MSB down recovers the binary count.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_cur;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             ovf_q;
  logic             unf_q;

  // Next-count decode: load beats a single step; inc and dec together cancel.
  always_comb begin
    bin_cur  = gray_to_bin(gray_q);
    bin_nxt  = bin_cur;
    ovf_nxt  = 1'b0;
    unf_nxt  = 1'b0;
    if (load_enable) begin
      bin_nxt = load_value;
    end else if (increment && !decrement) begin
      if (bin_cur == MAX_BIN) begin
        ovf_nxt = 1'b1;
        if (!SATURATE) bin_nxt = '0;
      end else begin
        bin_nxt = bin_cur + 1'b1;
      end
    end else if (decrement && !increment) begin
      if (bin_cur == '0) begin
        unf_nxt = 1'b1;
        if (!SATURATE) bin_nxt = MAX_BIN;
      end else begin
        bin_nxt = bin_cur - 1'b1;
      end
    end
    gray_nxt = bin_to_gray(bin_nxt);
  end

  // Gray state and flag pulses; reset wins over everything and drops pending pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      gray_q <= RST_GRAY;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      gray_q <= gray_nxt;
      ovf_q  <= ovf_nxt;
      unf_q  <= unf_nxt;
    end
  end

`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
  logic [WIDTH-1:0] bin_q;

  // Shadow binary register tracks the same next value as the Gray flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q <= RST_BIN;
    end else begin
      bin_q <= bin_nxt;
    end
  end

  assign binary = bin_q;
`endif

  // Gray leaves straight from flops so other domains can sample it.
  assign gray      = gray_q;
  assign at_max    = (gray_q == MAX_GRAY);
  assign at_min    = (gray_q == '0);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       increment;
  logic       decrement;
  logic       load_enable;
  logic [7:0] load_value;

  logic [7:0] gray_w,  gray_s,  gray_r;
  logic       amax_w,  amax_s,  amax_r;
  logic       amin_w,  amin_s,  amin_r;
  logic       ovf_w,   ovf_s,   ovf_r;
  logic       unf_w,   unf_s,   unf_r;
`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
  logic [7:0] bin_w, bin_s, bin_r;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Wrapping counter, reset 0.
  gray_counter #(.WIDTH(8), .RESET_VALUE(0), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .increment(increment), .decrement(decrement),
    .load_enable(load_enable), .load_value(load_value), .gray(gray_w),
`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
    .binary(bin_w),
`endif
    .at_max(amax_w), .at_min(amin_w), .overflow(ovf_w), .underflow(unf_w));

  // Saturating counter, reset 0.
  gray_counter #(.WIDTH(8), .RESET_VALUE(0), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .increment(increment), .decrement(decrement),
    .load_enable(load_enable), .load_value(load_value), .gray(gray_s),
`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
    .binary(bin_s),
`endif
    .at_max(amax_s), .at_min(amin_s), .overflow(ovf_s), .underflow(unf_s));

  // Wrapping counter, reset 3.
  gray_counter #(.WIDTH(8), .RESET_VALUE(3), .SATURATE(1'b0)) u_rv3 (
    .clock(clock), .reset(reset), .increment(increment), .decrement(decrement),
    .load_enable(load_enable), .load_value(load_value), .gray(gray_r),
`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
    .binary(bin_r),
`endif
    .at_max(amax_r), .at_min(amin_r), .overflow(ovf_r), .underflow(unf_r));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic i, input logic d, input logic l, input logic [7:0] v);
    reset       = r;
    increment   = i;
    decrement   = d;
    load_enable = l;
    load_value  = v;
  endtask

  function automatic logic [7:0] ref_g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  logic [7:0] prev;
  logic [7:0] expg;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // Reset state.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_gray",  gray_w, 8'h00);
    check("rst_amin",  amin_w, 1'b1);
    check("rst_amax",  amax_w, 1'b0);
    check("rst_ovf",   ovf_w,  1'b0);
    check("rst_unf",   unf_w,  1'b0);
    check("rst3_gray", gray_r, 8'h02);
    check("rst3_amin", amin_r, 1'b0);

    // Decrement from zero: wrap vs saturate.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check("dec0_wrap_gray", gray_w, 8'h80);
    check("dec0_wrap_unf",  unf_w,  1'b1);
    check("dec0_wrap_amax", amax_w, 1'b1);
    check("dec0_sat_gray",  gray_s, 8'h00);
    check("dec0_sat_unf",   unf_s,  1'b1);
    check("dec0_sat_amin",  amin_s, 1'b1);
    check("dec_rv3_gray",   gray_r, 8'h03);   // binary 2
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("unf_pulse_end_w", unf_w, 1'b0);
    check("unf_pulse_end_s", unf_s, 1'b0);
    check("hold_gray",       gray_w, 8'h80);

    // 256 increments from zero.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    prev = gray_w;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int n = 1; n <= 256; n++) begin
      step();
      expg = 8'(n) ^ (8'(n) >> 1);
      check($sformatf("inc_gray_%0d", n), gray_w, expg);
      check($sformatf("inc_onebit_%0d", n), $countones(prev ^ gray_w), 1);
      prev = gray_w;
      if (n == 255) begin
        check("inc255_gray", gray_w, 8'h80);
        check("inc255_amax", amax_w, 1'b1);
        check("inc255_ovf",  ovf_w,  1'b0);
      end
      if (n == 256) begin
        check("inc256_ovf",      ovf_w,  1'b1);
        check("inc256_amin",     amin_w, 1'b1);
        check("inc256_sat_gray", gray_s, 8'h80);
        check("inc256_sat_ovf",  ovf_s,  1'b1);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("ovf_pulse_end_w", ovf_w, 1'b0);
    check("ovf_pulse_end_s", ovf_s, 1'b0);

    // Load beats a concurrent increment.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    step();
    check("load_gray", gray_w, 8'hF7);
    check("load_ovf",  ovf_w,  1'b0);
    check("load_unf",  unf_w,  1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    check("load_inc_gray", gray_w, 8'hF5);   // binary A6

    // Increment and decrement together hold.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    step();
    check("load10_gray", gray_w, 8'h18);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    check("incdec_gray", gray_w, 8'h18);
    check("incdec_ovf",  ovf_w,  1'b0);
    check("incdec_unf",  unf_w,  1'b0);

    // Reset with a pending overflow pulse and a concurrent load.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    check("pre_rst_ovf", ovf_w, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    step();
    check("rst_mid_gray",  gray_w, 8'h00);
    check("rst_mid_ovf",   ovf_w,  1'b0);
    check("rst_mid_gray3", gray_r, 8'h02);

`ifdef GRAY_COUNTER_BINARY_OUTPUT_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("bin_rst_w", bin_w, 8'h00);
    check("bin_rst_r", bin_r, 8'h03);
    for (int c = 0; c < 1000; c++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
      step();
      check("bin_w", bin_w, ref_g2b(gray_w));
      check("bin_s", bin_s, ref_g2b(gray_s));
      check("bin_r", bin_r, ref_g2b(gray_r));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
